// File: rtl/fp_mac_pkg.sv
// rtl/fp_mac_pkg.sv - shared widths and FSM encoding for the FP MAC alignment path
//
// Purpose : default datapath widths for the mantissa alignment stage and the
//           state encoding of the multi-pass shift controller.
// Contents: DEF_DATA_W, DEF_SHAMT_W, DEF_STEP_W, DEF_MAX_STEP, state_t.
package fp_mac_pkg;

  localparam int DEF_DATA_W   = 24;
  localparam int DEF_SHAMT_W  = 8;
  localparam int DEF_STEP_W   = 3;
  localparam int DEF_MAX_STEP = (1 << DEF_STEP_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - log-stage right rotator used as the per-pass shift step
//
// Purpose : rotates a vector of LANES lanes (WIDTH bits each) right by sel lanes.
//           Rotation rather than shift keeps this block free of fill policy; the
//           caller masks the vacated upper lanes and inspects the dropped ones.
// Ports   : data_in  [WIDTH*LANES-1:0]  vector to rotate
//           sel      [SEL_W-1:0]        rotate amount in lanes
//           data_out [WIDTH*LANES-1:0]  rotated vector
module barrel_shifter #(
  parameter int WIDTH = 1,
  parameter int LANES = 24,
  parameter int SEL_W = 3
) (
  input  logic [WIDTH*LANES-1:0] data_in,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH*LANES-1:0] data_out
);

  localparam int TOTAL_W = WIDTH * LANES;

  logic [TOTAL_W-1:0] stage [SEL_W+1];

  assign stage[0] = data_in;

  // Stage k rotates by 2^k lanes when sel[k] is set.
  for (genvar k = 0; k < SEL_W; k++) begin : g_stage
    localparam int AMT = (1 << k) * WIDTH;
    logic [TOTAL_W-1:0] rotated;
    assign rotated      = {stage[k][AMT-1:0], stage[k][TOTAL_W-1:AMT]};
    assign stage[k+1]   = sel[k] ? rotated : stage[k];
  end

  assign data_out = stage[SEL_W];

endmodule

// File: rtl/align_shift_ctrl.sv
// rtl/align_shift_ctrl.sv - multi-pass mantissa right-alignment controller with sticky
//
// Purpose : shifts an accepted mantissa right by in_shamt using at most MAX_STEP
//           positions per cycle, OR-ing every dropped bit into a sticky flag.
// Ports   : clk, rst          clock, synchronous active-high reset
//           in_valid/in_ready request handshake; in_data, in_shamt sampled on accept
//           out_valid/out_ready result handshake; out_data, out_sticky held in DONE
//           busy              high while an operation is in SHIFT or DONE
module align_shift_ctrl
  import fp_mac_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int STEP_W  = DEF_STEP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sticky,
  output logic               busy
);

  localparam int                 MAX_STEP   = (1 << STEP_W) - 1;
  localparam logic [SHAMT_W-1:0] STEP_LIMIT = SHAMT_W'(MAX_STEP);
  localparam logic [SHAMT_W-1:0] SAT_LIMIT  = SHAMT_W'(DATA_W);
  localparam logic [DATA_W-1:0]  ALL_ONES   = {DATA_W{1'b1}};

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q;
  logic               sticky_q;
  logic [SHAMT_W-1:0] rem_q;

  logic               accept;
  logic               in_zero;
  logic               in_sat;
  logic [STEP_W-1:0]  step;
  logic [DATA_W-1:0]  rot_data;
  logic [DATA_W-1:0]  keep_mask;
  logic [DATA_W-1:0]  drop_mask;
  logic [DATA_W-1:0]  shifted;
  logic               step_sticky;
  logic               last_pass;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_data   = data_q;
  assign out_sticky = sticky_q;

  assign accept  = in_valid & in_ready;
  assign in_zero = (in_shamt == '0);
  // Full-width compare so large amounts such as 255 take the early exit.
  assign in_sat  = (in_shamt >= SAT_LIMIT);

  assign step = (rem_q < STEP_LIMIT) ? rem_q[STEP_W-1:0] : STEP_W'(MAX_STEP);

  barrel_shifter #(
    .WIDTH (1),
    .LANES (DATA_W),
    .SEL_W (STEP_W)
  ) u_step_shifter (
    .data_in  (data_q),
    .sel      (step),
    .data_out (rot_data)
  );

  // The rotator wraps the low bits to the top; clear those lanes so the
  // result is a zero-filled shift, and route the dropped bits to sticky.
  assign keep_mask   = ALL_ONES >> step;
  assign drop_mask   = ~(ALL_ONES << step);
  assign shifted     = rot_data & keep_mask;
  assign step_sticky = |(data_q & drop_mask);
  assign last_pass   = (rem_q == SHAMT_W'(step));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_zero || in_sat) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (last_pass) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      sticky_q <= 1'b0;
      rem_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rem_q <= in_shamt;
            if (in_sat) begin
              data_q   <= '0;
              sticky_q <= |in_data;
            end else begin
              data_q   <= in_data;
              sticky_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          data_q   <= shifted;
          sticky_q <= sticky_q | step_sticky;
          rem_q    <= rem_q - SHAMT_W'(step);
        end
        default: begin
          data_q   <= data_q;
          sticky_q <= sticky_q;
          rem_q    <= rem_q;
        end
      endcase
    end
  end

endmodule
